// File: rtl/c432_key_sequencer.sv
// Serial key loader for the locked c432 core: shifts KEY_W bits LSB first, checks an even-parity beat, commits on pass.
// Optional permanent lockout after MAX_FAIL consecutive parity failures when C432_KEYSEQ_LOCKOUT_EN is defined.
module c432_key_sequencer #(
    parameter int KEY_W    = 10,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_start,
    input  logic             key_valid,
    input  logic             key_bit,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_armed,
    output logic             key_fault,
    output logic             busy,
    output logic             locked_out
);

    localparam int CNT_W = $clog2(KEY_W + 1);

`ifdef C432_KEYSEQ_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOCK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    // MAX_FAIL only matters with lockout; an empty block keeps it referenced.
    if (MAX_FAIL < 1) begin : g_max_fail_unused
    end
`endif

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               armed_q, armed_d;
    logic               fault_q, fault_d;
`ifdef C432_KEYSEQ_LOCKOUT_EN
    logic [FAIL_W-1:0]  fail_q, fail_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            key_q    <= '0;
            armed_q  <= 1'b0;
            fault_q  <= 1'b0;
`ifdef C432_KEYSEQ_LOCKOUT_EN
            fail_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            armed_q  <= armed_d;
            fault_q  <= fault_d;
`ifdef C432_KEYSEQ_LOCKOUT_EN
            fail_q   <= fail_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        armed_d  = armed_q;
        fault_d  = fault_q;
`ifdef C432_KEYSEQ_LOCKOUT_EN
        fail_d   = fail_q;
`endif
        if (clear
`ifdef C432_KEYSEQ_LOCKOUT_EN
            && (state_q != LOCK)
`endif
           ) begin
            // Zeroize wins over start and beats; the failure history survives it.
            state_d  = IDLE;
            shadow_d = '0;
            cnt_d    = '0;
            key_d    = '0;
            armed_d  = 1'b0;
            fault_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d  = SHIFT;
                        shadow_d = '0;
                        cnt_d    = '0;
                        fault_d  = 1'b0;
                    end
                end
                SHIFT: begin
                    if (load_start) begin
                        shadow_d = '0;
                        cnt_d    = '0;
                    end else if (key_valid) begin
                        shadow_d[cnt_q] = key_bit;
                        cnt_d           = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(KEY_W - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (load_start) begin
                        state_d  = SHIFT;
                        shadow_d = '0;
                        cnt_d    = '0;
                    end else if (key_valid) begin
                        state_d = IDLE;
                        if ((^shadow_q ^ key_bit) == 1'b0) begin
                            key_d   = shadow_q;
                            armed_d = 1'b1;
`ifdef C432_KEYSEQ_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end else begin
                            key_d   = '0;
                            armed_d = 1'b0;
                            fault_d = 1'b1;
`ifdef C432_KEYSEQ_LOCKOUT_EN
                            if (fail_q != FAIL_W'(MAX_FAIL)) begin
                                fail_d = fail_q + 1'b1;
                            end
                            if (fail_d == FAIL_W'(MAX_FAIL)) begin
                                state_d = LOCK;
                            end
`endif
                        end
                    end
                end
`ifdef C432_KEYSEQ_LOCKOUT_EN
                LOCK: begin
                    state_d = LOCK;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    assign key_ready = (state_q == SHIFT) || (state_q == PARITY);
    assign busy      = key_ready;
    assign key_out   = key_q;
    assign key_armed = armed_q;
    assign key_fault = fault_q;
`ifdef C432_KEYSEQ_LOCKOUT_EN
    assign locked_out = (state_q == LOCK);
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_c432_key_sequencer.sv
// Directed and randomized checks of the key sequencer against a load-level parity model.
module tb_c432_key_sequencer;

    localparam int KEY_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             load_start;
    logic             key_valid;
    logic             key_bit;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_armed;
    logic             key_fault;
    logic             busy;
    logic             locked_out;

    int tests = 0;
    int fails = 0;

    c432_key_sequencer #(.KEY_W(KEY_W), .MAX_FAIL(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load_start (load_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_armed  (key_armed),
        .key_fault  (key_fault),
        .busy       (busy),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle: outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Sends beats [from, to) of {par, key}; stall inserts an idle cycle before each odd beat.
    task automatic send_beats(input logic [KEY_W-1:0] key, input logic par, input int from,
                              input int to, input bit stall, inout int cycles);
        logic [KEY_W:0] word;
        word = {par, key};
        for (int i = from; i < to; i++) begin
            if (stall && (i % 2 == 1)) begin
                key_valid = 1'b0;
                key_bit   = $urandom_range(0, 1);
                step();
                cycles++;
            end
            key_valid = 1'b1;
            key_bit   = word[i];
            step();
            cycles++;
        end
        key_valid = 1'b0;
    endtask

    task automatic full_load(input logic [KEY_W-1:0] key, input logic par, input bit stall,
                             output int cycles);
        cycles = 0;
        start_load();
        cycles++;
        send_beats(key, par, 0, KEY_W + 1, stall, cycles);
    endtask

    function automatic bit parity_ok(input logic [KEY_W-1:0] key, input logic par);
        int ones;
        ones = par;
        for (int i = 0; i < KEY_W; i++) ones += key[i];
        return (ones % 2) == 0;
    endfunction

    task automatic check_idle_outputs(input string tag, input logic [KEY_W-1:0] k,
                                      input logic armed, input logic fault, input logic lock);
        chk({tag, ".key_out"}, 32'(key_out), 32'(k));
        chk({tag, ".armed"}, 32'(key_armed), 32'(armed));
        chk({tag, ".fault"}, 32'(key_fault), 32'(fault));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".ready"}, 32'(key_ready), 32'd0);
        chk({tag, ".locked"}, 32'(locked_out), 32'(lock));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int cyc;
        int consec;
        bit locked_m;
        logic [KEY_W-1:0] k, m_key;
        logic p, m_armed, m_fault;
        bit pass;

        rst_n = 1'b0; clear = 1'b0; load_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        #12;
        check_idle_outputs("reset", '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Good key at full rate: armed on cycle 12.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start.busy", 32'(busy), 32'd1);
        chk("start.ready", 32'(key_ready), 32'd1);
        cyc = 1;
        send_beats(10'h2D3, 1'b0, 0, 5, 1'b0, cyc);
        chk("midload.key_out_held", 32'(key_out), 32'd0);
        chk("midload.busy", 32'(busy), 32'd1);
        send_beats(10'h2D3, 1'b0, 5, KEY_W + 1, 1'b0, cyc);
        chk("good.cycles", 32'(cyc), 32'd12);
        check_idle_outputs("good", 10'h2D3, 1'b1, 1'b0, 1'b0);

        // Bad parity zeroes the applied key and raises the sticky fault.
        full_load(10'h2D3, 1'b1, 1'b0, cyc);
        check_idle_outputs("badpar", '0, 1'b0, 1'b1, 1'b0);
        step();
        chk("badpar.sticky", 32'(key_fault), 32'd1);
        start_load();
        chk("badpar.fault_cleared", 32'(key_fault), 32'd0);
        chk("badpar.busy_again", 32'(busy), 32'd1);

        // Restart after 5 beats; the restart-cycle beat is discarded.
        cyc = 0;
        send_beats(10'h3FF, 1'b0, 0, 5, 1'b0, cyc);
        load_start = 1'b1;
        key_valid  = 1'b1;
        key_bit    = 1'b1;
        step();
        load_start = 1'b0;
        key_valid  = 1'b0;
        chk("restart.key_out_unchanged", 32'(key_out), 32'd0);
        send_beats(10'h155, 1'b1, 0, KEY_W + 1, 1'b0, cyc);
        check_idle_outputs("restart", 10'h155, 1'b1, 1'b0, 1'b0);

        // Clear overrides a simultaneous load_start.
        full_load(10'h2D3, 1'b0, 1'b0, cyc);
        chk("preclear.key_out", 32'(key_out), 32'h2D3);
        clear = 1'b1;
        load_start = 1'b1;
        step();
        clear = 1'b0;
        load_start = 1'b0;
        check_idle_outputs("clear", '0, 1'b0, 1'b0, 1'b0);

        // Reset mid-SHIFT returns everything to zero at once.
        full_load(10'h2D3, 1'b0, 1'b0, cyc);
        start_load();
        cyc = 0;
        send_beats(10'h2D3, 1'b0, 0, 4, 1'b0, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid", '0, 1'b0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;
        step();

        // IDLE beats ignored, then a stalled load gives the same result.
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            step();
        end
        key_valid = 1'b0;
        check_idle_outputs("idle_beats", '0, 1'b0, 1'b0, 1'b0);
        full_load(10'h2D3, 1'b0, 1'b1, cyc);
        check_idle_outputs("stall", 10'h2D3, 1'b1, 1'b0, 1'b0);
        chk("stall.cycles", 32'(cyc), 32'd17);

        // Randomized loads against the load-level model.
        do_reset();
        m_key = '0; m_armed = 1'b0; m_fault = 1'b0; consec = 0; locked_m = 1'b0;
        for (int n = 0; n < 24; n++) begin
            k = KEY_W'($urandom);
            p = $urandom_range(0, 1);
            full_load(k, p, bit'($urandom_range(0, 1)), cyc);
            if (!locked_m) begin
                pass = parity_ok(k, p);
                m_key   = pass ? k : '0;
                m_armed = pass;
                m_fault = !pass;
                consec  = pass ? 0 : consec + 1;
`ifdef C432_KEYSEQ_LOCKOUT_EN
                if (consec >= 3) locked_m = 1'b1;
`endif
            end
            check_idle_outputs("rand", m_key, m_armed, m_fault, locked_m);
        end

        // Three consecutive bad loads, then a good one.
        do_reset();
        for (int n = 0; n < 3; n++) full_load(10'h2D3, 1'b1, 1'b0, cyc);
        full_load(10'h2D3, 1'b0, 1'b0, cyc);
`ifdef C432_KEYSEQ_LOCKOUT_EN
        check_idle_outputs("lock.fourth", '0, 1'b0, 1'b1, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_idle_outputs("lock.clear", '0, 1'b0, 1'b1, 1'b1);
        do_reset();
        check_idle_outputs("lock.reset", '0, 1'b0, 1'b0, 1'b0);
`else
        check_idle_outputs("nolock.fourth", 10'h2D3, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
